// File: rtl/vram_write_queue_pkg.sv
// Shared widths, entry layout and FSM encoding for the VRAM write queue.
// Also provides the lane priority encoder used by the splitter.
package vram_write_queue_pkg;

  localparam int VRAM_ADDR_W      = 17;
  localparam int VRAM_DATA_W      = 8;
  localparam int VRAM_WORD_ADDR_W = 15;
  localparam int VRAM_WQ_ENTRY_W  = 25;

  typedef enum logic {
    WQ_IDLE  = 1'b0,
    WQ_SPLIT = 1'b1
  } wq_state_e;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } wq_entry_t;

  // Lowest set byte lane wins; returns 0 for an all-zero mask.
  function automatic logic [1:0] lowest_lane(input logic [3:0] be);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (be[i]) lane = 2'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/vram_write_queue_if.sv
// CPU write port and arbiter read port of the VRAM write queue.
// slave = the queue itself, master = whatever drives the CPU side and drains the FIFO.
interface vram_write_queue_if #(
  parameter int DEPTH_LOG2 = 5
);
  logic                  cpu_start;
  logic [14:0]           cpu_addr;
  logic [31:0]           cpu_data;
  logic [3:0]            cpu_be;
  logic                  cpu_busy;
  logic                  cpu_done;
  logic                  fifo_rd_en;
  logic [16:0]           fifo_rd_addr;
  logic [7:0]            fifo_rd_data;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_level;

  modport slave (
    input  cpu_start, cpu_addr, cpu_data, cpu_be, fifo_rd_en,
    output cpu_busy, cpu_done, fifo_rd_addr, fifo_rd_data, fifo_empty, fifo_level
  );

  modport master (
    output cpu_start, cpu_addr, cpu_data, cpu_be, fifo_rd_en,
    input  cpu_busy, cpu_done, fifo_rd_addr, fifo_rd_data, fifo_empty, fifo_level
  );
endinterface

// File: rtl/vram_write_queue_fifo.sv
// Generic single-clock show-ahead FIFO with level/full/empty derived from wrapping pointers.
// Head is presented combinationally and forced to zero while empty.
module sync_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                rd_accept;
  logic                wr_accept;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (DEPTH_LOG2+1)'(DEPTH));

  // A write while full is only safe when the head leaves on the same edge.
  assign rd_accept = rd_en_i && !empty_o;
  assign wr_accept = wr_en_i && (!full_o || rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/vram_write_queue.sv
// Splits CPU word writes into byte entries and queues them for the SRAM arbiter.
//   state     | meaning
//   WQ_IDLE   | waiting for cpu_start; be==0 requests complete immediately
//   WQ_SPLIT  | pushing one enabled lane per edge, stalling while the FIFO is full
module vram_write_queue
  import vram_write_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic               clk100,
  input  logic               reset,
  vram_write_queue_if.slave  bus
);

  wq_state_e             state_q, state_d;
  logic [14:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            be_q, be_d;
  logic                  done_q, done_d;

  logic [1:0]            lane;
  logic [3:0]            be_rest;
  logic                  push;
  logic                  full;
  wq_entry_t             push_entry;
  wq_entry_t             head;

  assign lane    = lowest_lane(be_q);
  assign be_rest = be_q & ~(4'b0001 << lane);

  assign push_entry.addr = {addr_q, lane};
  assign push_entry.data = data_q[{lane, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      WQ_IDLE: begin
        if (bus.cpu_start) begin
          if (bus.cpu_be != 4'b0000) begin
            addr_d  = bus.cpu_addr;
            data_d  = bus.cpu_data;
            be_d    = bus.cpu_be;
            state_d = WQ_SPLIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WQ_SPLIT: begin
        if (!full) begin
          push = 1'b1;
          be_d = be_rest;
          if (be_rest == 4'b0000) begin
            done_d  = 1'b1;
            state_d = WQ_IDLE;
          end
        end
      end
      default: state_d = WQ_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q <= WQ_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      done_q  <= done_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH      (VRAM_WQ_ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (clk100),
    .rst_i     (reset),
    .wr_en_i   (push),
    .wr_data_i (push_entry),
    .rd_en_i   (bus.fifo_rd_en),
    .rd_data_o (head),
    .empty_o   (bus.fifo_empty),
    .full_o    (full),
    .level_o   (bus.fifo_level)
  );

  assign bus.cpu_busy     = (state_q == WQ_SPLIT);
  assign bus.cpu_done     = done_q;
  assign bus.fifo_rd_addr = head.addr;
  assign bus.fifo_rd_data = head.data;

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue: byte-queue reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_vram_write_queue;
  localparam int DL    = 5;
  localparam int DEPTH = 32;

  logic clk100 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk100 = ~clk100;

  vram_write_queue_if #(.DEPTH_LOG2(DL)) bus();
  vram_write_queue #(.DEPTH_LOG2(DL)) dut (.clk100(clk100), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of byte entries plus the remaining lanes of the pending word.
  logic [24:0] mq[$];
  logic [3:0]  m_be    = 4'b0;
  logic [14:0] m_addr  = '0;
  logic [31:0] m_data  = '0;
  logic        m_done  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_lvl;
  logic        m_d;
  bit          m_found;
  int          max_level = 0;

  always @(posedge clk100) begin
    if (reset) begin
      mq.delete();
      m_be    = 4'b0;
      m_done  = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_d   = 1'b0;
      m_lvl = mq.size();
      if (bus.fifo_rd_en && m_lvl > 0) void'(mq.pop_front());
      if (m_be != 4'b0) begin
        if (m_lvl < DEPTH) begin
          m_found = 1'b0;
          for (int i = 0; i < 4; i++) begin
            if (m_be[i] && !m_found) begin
              mq.push_back({m_addr, 2'(i), m_data[8*i +: 8]});
              m_be[i] = 1'b0;
              m_found = 1'b1;
            end
          end
          if (m_be == 4'b0) m_d = 1'b1;
        end
      end else if (bus.cpu_start) begin
        if (bus.cpu_be == 4'b0) m_d = 1'b1;
        else begin
          m_be   = bus.cpu_be;
          m_addr = bus.cpu_addr;
          m_data = bus.cpu_data;
        end
      end
      m_done = m_d;
    end
  end

  logic [24:0] m_head;
  always @(negedge clk100) begin
    if (m_valid) begin
      m_head = (mq.size() > 0) ? mq[0] : 25'd0;
      chk("busy",      32'(bus.cpu_busy),     32'(m_be != 4'b0));
      chk("done",      32'(bus.cpu_done),     32'(m_done));
      chk("empty",     32'(bus.fifo_empty),   32'(mq.size() == 0));
      chk("level",     32'(bus.fifo_level),   32'(mq.size()));
      chk("head_addr", 32'(bus.fifo_rd_addr), 32'(m_head[24:8]));
      chk("head_data", 32'(bus.fifo_rd_data), 32'(m_head[7:0]));
      if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
    end
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic start_word(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.cpu_start = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_data  = d;
    bus.cpu_be    = be;
    tick();
    bus.cpu_start = 1'b0;
  endtask

  // Latency = edges after the sampling edge until cpu_done is visible.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.cpu_done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic write_word(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int lat);
    start_word(a, d, be);
    wait_done(lat);
  endtask

  task automatic pop_one(output logic [24:0] e);
    bus.fifo_rd_en = 1'b1;
    e = {bus.fifo_rd_addr, bus.fifo_rd_data};
    tick();
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic test1_word(input string tag);
    int lat;
    logic [24:0] e;
    logic [24:0] exp_e [4];
    exp_e[0] = {17'h40, 8'hAA};
    exp_e[1] = {17'h41, 8'hBB};
    exp_e[2] = {17'h42, 8'hCC};
    exp_e[3] = {17'h43, 8'hDD};
    write_word(15'h0010, 32'hDDCCBBAA, 4'hF, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_level"}, 32'(bus.fifo_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      pop_one(e);
      chk({tag, "_entry"}, 32'(e), 32'(exp_e[i]));
    end
    chk({tag, "_empty_after"}, 32'(bus.fifo_empty), 32'd1);
  endtask

  int          lat;
  int          budget;
  int          idx;
  bit          saw_done;
  logic [24:0] e;

  initial begin
    bus.cpu_start  = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_data   = '0;
    bus.cpu_be     = '0;
    bus.fifo_rd_en = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy",  32'(bus.cpu_busy),     32'd0);
    chk("rst_done",  32'(bus.cpu_done),     32'd0);
    chk("rst_empty", 32'(bus.fifo_empty),   32'd1);
    chk("rst_level", 32'(bus.fifo_level),   32'd0);
    chk("rst_raddr", 32'(bus.fifo_rd_addr), 32'd0);
    chk("rst_rdata", 32'(bus.fifo_rd_data), 32'd0);
    reset = 1'b0;
    tick();

    // 1: full word
    test1_word("t1");

    // 2: sparse lanes
    write_word(15'h0000, 32'h44332211, 4'b1010, lat);
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_level", 32'(bus.fifo_level), 32'd2);
    pop_one(e);
    chk("t2_entry0", 32'(e), 32'({17'h1, 8'h22}));
    pop_one(e);
    chk("t2_entry1", 32'(e), 32'({17'h3, 8'h44}));
    chk("t2_empty", 32'(bus.fifo_empty), 32'd1);

    // 3: no lanes enabled
    write_word(15'h0123, 32'hCAFEF00D, 4'b0000, lat);
    chk("t3_latency", 32'(lat), 32'd0);
    chk("t3_level", 32'(bus.fifo_level), 32'd0);
    chk("t3_empty", 32'(bus.fifo_empty), 32'd1);
    tick();
    chk("t3_done_pulse", 32'(bus.cpu_done), 32'd0);

    // 4: fill, stall on full, then drain one per cycle
    for (int w = 0; w < 8; w++)
      write_word(15'(15'h200 + w), {8'(w), 8'(w + 8'h10), 8'(w + 8'h20), 8'(w + 8'h30)}, 4'hF, lat);
    chk("t4_full_level", 32'(bus.fifo_level), 32'd32);
    start_word(15'h300, 32'h9C9B9A99, 4'hF);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cpu_done === 1'b1) saw_done = 1'b1;
    end
    chk("t4_stall_busy", 32'(bus.cpu_busy), 32'd1);
    chk("t4_stall_nodone", 32'(saw_done), 32'd0);
    chk("t4_stall_level", 32'(bus.fifo_level), 32'd32);
    bus.fifo_rd_en = 1'b1;
    lat = 0;
    while (bus.cpu_done !== 1'b1 && lat < 50) begin
      tick();
      lat++;
      chk("t4_level_const", 32'(bus.fifo_level), 32'd31);
    end
    chk("t4_done_after_pops", 32'(lat), 32'd5);
    budget = 0;
    while (bus.fifo_empty !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    bus.fifo_rd_en = 1'b0;
    chk("t4_drain_cycles", 32'(budget), 32'd31);
    chk("t4_max_level", 32'(max_level), 32'd32);
    tick();

    // 5: concurrent producer and arbiter, 40 bytes across pointer wrap
    idx = 0;
    fork
      begin
        int plat;
        for (int w = 0; w < 10; w++)
          write_word(15'(15'h100 + w),
                     {8'(8'h83 + 4*w), 8'(8'h82 + 4*w), 8'(8'h81 + 4*w), 8'(8'h80 + 4*w)},
                     4'hF, plat);
      end
      begin
        int ab;
        logic [24:0] se;
        logic [24:0] xe;
        ab = 0;
        while (idx < 40 && ab < 2000) begin
          if (bus.fifo_empty === 1'b0) begin
            bus.fifo_rd_en = 1'b1;
            se = {bus.fifo_rd_addr, bus.fifo_rd_data};
            xe = {15'(15'h100 + idx / 4), 2'(idx % 4), 8'(8'h80 + idx)};
            chk("t5_entry", 32'(se), 32'(xe));
            idx++;
          end else begin
            bus.fifo_rd_en = 1'b0;
          end
          tick();
          ab++;
        end
        bus.fifo_rd_en = 1'b0;
      end
    join
    chk("t5_count", 32'(idx), 32'd40);
    chk("t5_empty_after", 32'(bus.fifo_empty), 32'd1);
    tick();

    // 6: reset on the second push
    start_word(15'h0055, 32'h11223344, 4'hF);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_busy", 32'(bus.cpu_busy), 32'd0);
    chk("t6_empty", 32'(bus.fifo_empty), 32'd1);
    chk("t6_level", 32'(bus.fifo_level), 32'd0);
    chk("t6_done", 32'(bus.cpu_done), 32'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cpu_done === 1'b1) saw_done = 1'b1;
    end
    chk("t6_no_done", 32'(saw_done), 32'd0);
    test1_word("t6");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
